// File: rtl/rfu_mp_pkg.sv
// Shared types and helpers for the multi-port rename/forwarding register file (rfu_mp).
package rfu_mp_pkg;

  localparam int unsigned PKG_TAG_W = 4;

  typedef logic [PKG_TAG_W-1:0] tag_t;
  typedef logic [4:0]           reg_addr_t;

  // Tag value 0 means "no producer".
  localparam tag_t NO_TAG = '0;

  typedef struct packed {
    logic        wr;
    tag_t        tag;
    logic [31:0] wdata;
  } cdb_port_t;

  // Population count of the 32 busy bits.
  function automatic logic [5:0] count_ones(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rfu_mp_entry.sv
// One architectural register: value, busy flag and producer tag, with
// dispatch/CDB/flush priority resolution.
module rfu_mp_entry
  import rfu_mp_pkg::*;
#(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned N_CDB  = 2,
  parameter int unsigned N_DISP = 2,
  parameter int unsigned IDX    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [N_DISP-1:0]             disp_wr,
  input  logic [N_DISP-1:0][4:0]        disp_rd,
  input  logic [N_DISP-1:0][TAG_W-1:0]  disp_tag,
  input  logic [N_CDB-1:0]              cdb_wr,
  input  logic [N_CDB-1:0][TAG_W-1:0]   cdb_tag,
  input  logic [N_CDB-1:0][31:0]        cdb_wdata,
  output logic [31:0]                   value,
  output logic                          busy,
  output logic [TAG_W-1:0]              tag
);

  logic              disp_hit;
  logic [TAG_W-1:0]  disp_sel;
  logic              cdb_hit;
  logic [31:0]       cdb_sel;
  logic [31:0]       value_n;
  logic              busy_n;
  logic [TAG_W-1:0]  tag_n;

  // Dispatch claim: later lanes are younger, so the highest lane index wins.
  always_comb begin
    disp_hit = 1'b0;
    disp_sel = '0;
    for (int unsigned l = 0; l < N_DISP; l++) begin
      if (disp_wr[l] && (disp_rd[l] == reg_addr_t'(IDX))) begin
        disp_hit = 1'b1;
        disp_sel = disp_tag[l];
      end
    end
  end

  // CDB capture: first matching port (lowest index) wins.
  always_comb begin
    cdb_hit = 1'b0;
    cdb_sel = '0;
    for (int unsigned p = 0; p < N_CDB; p++) begin
      if (!cdb_hit && busy && cdb_wr[p] && (cdb_tag[p] != TAG_W'(NO_TAG)) &&
          (cdb_tag[p] == tag)) begin
        cdb_hit = 1'b1;
        cdb_sel = cdb_wdata[p];
      end
    end
  end

  // Next state: the CDB value always lands; flush beats dispatch beats CDB for busy/tag.
  always_comb begin
    value_n = cdb_hit ? cdb_sel : value;
    busy_n  = busy;
    tag_n   = tag;
    if (flush) begin
      busy_n = 1'b0;
      tag_n  = '0;
    end else if (disp_hit) begin
      busy_n = 1'b1;
      tag_n  = disp_sel;
    end else if (cdb_hit) begin
      busy_n = 1'b0;
      tag_n  = '0;
    end
  end

  // State register with synchronous reset overriding all updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      busy  <= 1'b0;
      tag   <= '0;
    end else begin
      value <= value_n;
      busy  <= busy_n;
      tag   <= tag_n;
    end
  end

endmodule

// File: rtl/rfu_mp.sv
// Multi-port rename register file with CDB capture and combinational read ports.
// Optional macro RFU_MP_BYPASS_EN forwards a same-cycle CDB result to read ports.
module rfu_mp
  import rfu_mp_pkg::*;
#(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned N_CDB  = 2,
  parameter int unsigned N_DISP = 2,
  parameter int unsigned N_RP   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_DISP-1:0]             disp_wr,
  input  logic [N_DISP-1:0][4:0]        disp_rd,
  input  logic [N_DISP-1:0][TAG_W-1:0]  disp_tag,
  input  logic [N_CDB-1:0]              cdb_wr,
  input  logic [N_CDB-1:0][TAG_W-1:0]   cdb_tag,
  input  logic [N_CDB-1:0][31:0]        cdb_wdata,
  input  logic                          flush,
  input  logic [N_RP-1:0][4:0]          rp_addr,
  output logic [N_RP-1:0][31:0]         rp_rdata,
  output logic [N_RP-1:0]               rp_busy,
  output logic [N_RP-1:0][TAG_W-1:0]    rp_tag,
  output logic [5:0]                    busy_cnt
);

  logic [31:0]      reg_val [32];
  logic [31:0]      reg_busy;
  logic [TAG_W-1:0] reg_tag [32];

  // x0 is hardwired: zero value, never busy, no tag.
  assign reg_val[0]  = '0;
  assign reg_busy[0] = 1'b0;
  assign reg_tag[0]  = '0;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    rfu_mp_entry #(
      .TAG_W  (TAG_W),
      .N_CDB  (N_CDB),
      .N_DISP (N_DISP),
      .IDX    (r)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .disp_wr   (disp_wr),
      .disp_rd   (disp_rd),
      .disp_tag  (disp_tag),
      .cdb_wr    (cdb_wr),
      .cdb_tag   (cdb_tag),
      .cdb_wdata (cdb_wdata),
      .value     (reg_val[r]),
      .busy      (reg_busy[r]),
      .tag       (reg_tag[r])
    );
  end

`ifdef RFU_MP_BYPASS_EN
  logic byp_hit;
`endif

  // Read ports: registered state only; same-cycle dispatch is never visible.
  always_comb begin
    rp_rdata = '0;
    rp_busy  = '0;
    rp_tag   = '0;
`ifdef RFU_MP_BYPASS_EN
    byp_hit  = 1'b0;
`endif
    for (int unsigned p = 0; p < N_RP; p++) begin
      rp_rdata[p] = reg_val[rp_addr[p]];
      if (reg_busy[rp_addr[p]]) begin
        rp_busy[p] = 1'b1;
        rp_tag[p]  = reg_tag[rp_addr[p]];
      end
`ifdef RFU_MP_BYPASS_EN
      byp_hit = 1'b0;
      for (int unsigned c = 0; c < N_CDB; c++) begin
        if (!byp_hit && reg_busy[rp_addr[p]] && cdb_wr[c] &&
            (cdb_tag[c] != TAG_W'(NO_TAG)) && (cdb_tag[c] == reg_tag[rp_addr[p]])) begin
          byp_hit     = 1'b1;
          rp_rdata[p] = cdb_wdata[c];
          rp_busy[p]  = 1'b0;
          rp_tag[p]   = '0;
        end
      end
`endif
    end
  end

  // Busy count trails the busy bits by one cycle.
  always_ff @(posedge clk) begin
    if (rst) busy_cnt <= '0;
    else     busy_cnt <= count_ones(reg_busy);
  end

endmodule

// File: tb/tb_rfu_mp.sv
// Self-checking bench for rfu_mp: reference model + expectation queue,
// directed scenarios followed by constrained-random traffic.
module tb_rfu_mp;
  import rfu_mp_pkg::*;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned N_CDB  = 2;
  localparam int unsigned N_DISP = 2;
  localparam int unsigned N_RP   = 4;

  logic                          clk;
  logic                          rst;
  logic [N_DISP-1:0]             disp_wr;
  logic [N_DISP-1:0][4:0]        disp_rd;
  logic [N_DISP-1:0][TAG_W-1:0]  disp_tag;
  logic [N_CDB-1:0]              cdb_wr;
  logic [N_CDB-1:0][TAG_W-1:0]   cdb_tag;
  logic [N_CDB-1:0][31:0]        cdb_wdata;
  logic                          flush;
  logic [N_RP-1:0][4:0]          rp_addr;
  logic [N_RP-1:0][31:0]         rp_rdata;
  logic [N_RP-1:0]               rp_busy;
  logic [N_RP-1:0][TAG_W-1:0]    rp_tag;
  logic [5:0]                    busy_cnt;

  rfu_mp #(
    .TAG_W  (TAG_W),
    .N_CDB  (N_CDB),
    .N_DISP (N_DISP),
    .N_RP   (N_RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_wr   (disp_wr),
    .disp_rd   (disp_rd),
    .disp_tag  (disp_tag),
    .cdb_wr    (cdb_wr),
    .cdb_tag   (cdb_tag),
    .cdb_wdata (cdb_wdata),
    .flush     (flush),
    .rp_addr   (rp_addr),
    .rp_rdata  (rp_rdata),
    .rp_busy   (rp_busy),
    .rp_tag    (rp_tag),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Reference model state
  logic [31:0]      m_val  [32];
  logic [31:0]      m_busy;
  logic [TAG_W-1:0] m_tag  [32];
  logic [5:0]       m_cnt;

  typedef struct packed {
    logic [N_RP-1:0][31:0]      rdata;
    logic [N_RP-1:0]            busy;
    logic [N_RP-1:0][TAG_W-1:0] tag;
    logic [5:0]                 cnt;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    e.cnt = m_cnt;
    for (int p = 0; p < N_RP; p++) begin
      int a;
      a = int'(rp_addr[p]);
      e.rdata[p] = m_val[a];
      e.busy[p]  = m_busy[a];
      e.tag[p]   = m_busy[a] ? m_tag[a] : '0;
`ifdef RFU_MP_BYPASS_EN
      if (m_busy[a]) begin
        for (int c = N_CDB - 1; c >= 0; c--) begin
          if (cdb_wr[c] && cdb_tag[c] != 0 && cdb_tag[c] == m_tag[a]) begin
            e.rdata[p] = cdb_wdata[c];
            e.busy[p]  = 1'b0;
            e.tag[p]   = '0;
          end
        end
      end
`endif
    end
    return e;
  endfunction

  task automatic model_clock();
    logic [5:0]       c;
    logic             dhit;
    logic [TAG_W-1:0] dtag;
    logic             chit;
    logic [31:0]      cdata;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_val[r] = '0;
        m_tag[r] = '0;
      end
      m_busy = '0;
      m_cnt  = '0;
    end else begin
      c = '0;
      for (int r = 0; r < 32; r++) if (m_busy[r]) c = c + 6'd1;
      for (int r = 1; r < 32; r++) begin
        dhit = 1'b0;
        dtag = '0;
        for (int l = N_DISP - 1; l >= 0; l--) begin
          if (!dhit && disp_wr[l] && int'(disp_rd[l]) == r) begin
            dhit = 1'b1;
            dtag = disp_tag[l];
          end
        end
        chit  = 1'b0;
        cdata = '0;
        for (int p = 0; p < N_CDB; p++) begin
          if (!chit && m_busy[r] && cdb_wr[p] && cdb_tag[p] != 0 && cdb_tag[p] == m_tag[r]) begin
            chit  = 1'b1;
            cdata = cdb_wdata[p];
          end
        end
        if (chit) m_val[r] = cdata;
        if (flush) begin
          m_busy[r] = 1'b0;
          m_tag[r]  = '0;
        end else if (dhit) begin
          m_busy[r] = 1'b1;
          m_tag[r]  = dtag;
        end else if (chit) begin
          m_busy[r] = 1'b0;
          m_tag[r]  = '0;
        end
      end
      m_cnt = c;
    end
  endtask

  // Called at posedge+1 with inputs driven: queue expectation, sample, advance clock.
  task automatic cycle();
    exp_t e;
    sb_q.push_back(predict());
    #1;
    e = sb_q.pop_front();
    for (int p = 0; p < N_RP; p++) begin
      check($sformatf("rdata[%0d]", p), rp_rdata[p], e.rdata[p]);
      check($sformatf("busy[%0d]", p), 32'(rp_busy[p]), 32'(e.busy[p]));
      check($sformatf("tag[%0d]", p), 32'(rp_tag[p]), 32'(e.tag[p]));
    end
    check("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    rst       = 1'b0;
    flush     = 1'b0;
    disp_wr   = '0;
    disp_rd   = '0;
    disp_tag  = '0;
    cdb_wr    = '0;
    cdb_tag   = '0;
    cdb_wdata = '0;
  endtask

  task automatic disp(input int l, input int rd, input int t);
    disp_wr[l]  = 1'b1;
    disp_rd[l]  = 5'(rd);
    disp_tag[l] = TAG_W'(t);
  endtask

  task automatic cdb(input int p, input int t, input logic [31:0] d);
    cdb_wr[p]    = 1'b1;
    cdb_tag[p]   = TAG_W'(t);
    cdb_wdata[p] = d;
  endtask

  initial begin
    idle();
    rp_addr = '0;
    rst = 1'b1;
    @(posedge clk);
    model_clock();
    #1;
    // reset state observed while rst still held
    rp_addr = {5'd9, 5'd7, 5'd5, 5'd0};
    cycle();
    #1;
    check("rst_cnt", 32'(busy_cnt), 32'd0);
    check("rst_busy", 32'(rp_busy), 32'd0);
    idle();

    // dispatch rd5 tag3, then CDB0 tag3 resolves it
    disp(0, 5, 3);
    cycle();
    idle();
    cdb(0, 3, 32'hDEADBEEF);
    rp_addr[0] = 5'd5;
    #1;
`ifdef RFU_MP_BYPASS_EN
    check("s35_byp_data", rp_rdata[0], 32'hDEADBEEF);
    check("s35_byp_busy", 32'(rp_busy[0]), 32'd0);
`else
    check("s35_busy", 32'(rp_busy[0]), 32'd1);
    check("s35_tag", 32'(rp_tag[0]), 32'd3);
`endif
    cycle();
    idle();
    #1;
    check("s35_data", rp_rdata[0], 32'hDEADBEEF);
    check("s35_done", 32'(rp_busy[0]), 32'd0);
    cycle();

    // two lanes claim r7: lane 1 (tag 4) is youngest and wins
    disp(0, 7, 2);
    disp(1, 7, 4);
    cycle();
    idle();
    cdb(0, 2, 32'h00000999);
    rp_addr[1] = 5'd7;
    cycle();
    idle();
    #1;
    check("s36_busy", 32'(rp_busy[1]), 32'd1);
    check("s36_tag", 32'(rp_tag[1]), 32'd4);
    check("s36_data", rp_rdata[1], 32'd0);
    cycle();

    // r9 busy tag6; redispatch tag1 alongside CDB tag6
    disp(0, 9, 6);
    cycle();
    idle();
    disp(1, 9, 1);
    cdb(1, 6, 32'h55);
    rp_addr[2] = 5'd9;
    cycle();
    idle();
    #1;
    check("s37_data", rp_rdata[2], 32'h55);
    check("s37_busy", 32'(rp_busy[2]), 32'd1);
    check("s37_tag", 32'(rp_tag[2]), 32'd1);
    cycle();

    // three busy (r7, r9, r11); flush with dispatch rd3
    disp(0, 11, 7);
    cycle();
    idle();
    cycle();
    #1;
    check("s38_cnt3", 32'(busy_cnt), 32'd3);
    flush = 1'b1;
    disp(0, 3, 5);
    rp_addr = {5'd11, 5'd9, 5'd7, 5'd3};
    cycle();
    idle();
    cycle();
    #1;
    check("s38_cnt0", 32'(busy_cnt), 32'd0);
    check("s38_rpbusy", 32'(rp_busy), 32'd0);
    cycle();

    // CDB1 resolves r4 (bypass visible same cycle only in the bypass build)
    disp(0, 4, 5);
    cycle();
    idle();
    cdb(1, 5, 32'h1234);
    rp_addr[2] = 5'd4;
    #1;
`ifdef RFU_MP_BYPASS_EN
    check("s39_byp_data", rp_rdata[2], 32'h1234);
    check("s39_byp_busy", 32'(rp_busy[2]), 32'd0);
`else
    check("s39_busy", 32'(rp_busy[2]), 32'd1);
`endif
    cycle();
    idle();
    #1;
    check("s39_data", rp_rdata[2], 32'h1234);
    check("s39_done", 32'(rp_busy[2]), 32'd0);
    cycle();

    // x0 ignores dispatch and CDB
    rp_addr[3] = 5'd0;
    disp(0, 0, 2);
    cycle();
    idle();
    cdb(0, 2, 32'hFFFF0000);
    cycle();
    idle();
    cycle();
    #1;
    check("s40_data", rp_rdata[3], 32'd0);
    check("s40_busy", 32'(rp_busy[3]), 32'd0);
    check("s40_cnt", 32'(busy_cnt), 32'd0);
    cycle();

    // mid-operation reset with concurrent dispatch
    disp(0, 12, 3);
    disp(1, 13, 4);
    cycle();
    idle();
    rst = 1'b1;
    disp(0, 14, 5);
    cdb(0, 3, 32'hABCD);
    rp_addr = {5'd14, 5'd13, 5'd12, 5'd1};
    cycle();
    idle();
    cycle();
    #1;
    check("s30_busy", 32'(rp_busy), 32'd0);
    check("s30_data", rp_rdata[1], 32'd0);

    // constrained-random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int l = 0; l < N_DISP; l++) begin
        if ($urandom_range(0, 2) != 0) begin
          disp(l, (i % 7 == 0 && l == 1) ? int'(disp_rd[0]) : int'($urandom_range(0, 31)),
               int'($urandom_range(0, 15)));
        end
      end
      for (int p = 0; p < N_CDB; p++) begin
        if ($urandom_range(0, 1) != 0) begin
          cdb(p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'(m_tag[$urandom_range(1, 31)]),
              $urandom());
        end
      end
      for (int p = 0; p < N_RP; p++) rp_addr[p] = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
